pipe_hazard_ctrl: RTL and testbench

Central hazard and sequencing controller for the 5-stage pipelined CPU. Compares register fields and control bits from the ID, EX and MEM stages. Drives stall and flush strobes to the PC and to the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, and selects the next-PC source on taken branches and jumps. Also holds the whole pipeline during multi-cycle data-memory accesses through a req/ready handshake with a timeout.

---
 rtl/pipe_pkg.sv | 17 +
 rtl/pipe_perf_cnt.sv | 27 ++
 rtl/pipe_hazard_ctrl.sv | 128 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard controller: NPC op encodings,
// register-index width and the hazard FSM state type.
package pipe_pkg;

  localparam int REG_W = 5;

  localparam logic [1:0] NPC_SEQ = 2'b00;
  localparam logic [1:0] NPC_BR  = 2'b01;
  localparam logic [1:0] NPC_J   = 2'b10;
  localparam logic [1:0] NPC_JR  = 2'b11;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hz_state_e;

endpackage

// File: rtl/pipe_perf_cnt.sv
// Stall-cycle and redirect counters for the hazard controller; only built
// when PIPE_PERF_CNT_EN is defined.
`ifdef PIPE_PERF_CNT_EN
module pipe_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_evt,
  input  logic             flush_evt,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  // Both counters wrap naturally at 2^CNT_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (stall_evt) stall_cycles <= stall_cycles + CNT_W'(1);
      if (flush_evt) flush_events <= flush_events + CNT_W'(1);
    end
  end

endmodule
`endif

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline: load-use stalls,
// redirect flushes and data-memory wait handling. Optional PIPE_PERF_CNT_EN.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_MemRead,
  input  logic [REG_W-1:0] ex_wa,
  input  logic [1:0]       mem_NPCOp,
  input  logic             mem_MemRead,
  input  logic             mem_MemWrite,
  input  logic             dmem_ready,
  output logic             dmem_req,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             id_ex_stall,
  output logic             ex_mem_stall,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             mem_wb_flush,
  output logic [1:0]       npc_sel,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam int WC_W = $clog2(MEM_TIMEOUT + 1);

  hz_state_e       state, next_state;
  logic [WC_W-1:0] wait_cnt;
  logic            mem_acc, mem_miss, load_use, timeout;

  assign mem_acc  = mem_MemRead | mem_MemWrite;
  assign mem_miss = mem_acc & ~dmem_ready;
  assign load_use = ex_MemRead && (ex_wa != '0) &&
                    ((ex_wa == id_rs) || (id_uses_rt && (ex_wa == id_rt)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      state <= next_state;
      if (state == RUN && mem_miss)
        wait_cnt <= WC_W'(1);
      else if (state == MEM_WAIT && next_state == MEM_WAIT)
        wait_cnt <= wait_cnt + WC_W'(1);
      else
        wait_cnt <= '0;
      if (timeout) mem_err <= 1'b1;
    end
  end

  always_comb begin
    next_state   = state;
    dmem_req     = 1'b0;
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    id_ex_stall  = 1'b0;
    ex_mem_stall = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    mem_wb_flush = 1'b0;
    npc_sel      = NPC_SEQ;
    timeout      = 1'b0;
    unique case (state)
      RUN: begin
        dmem_req = mem_acc;
        // Memory outranks a redirect; the redirect proceeds once the access completes.
        if (mem_miss) begin
          {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall} = 4'b1111;
          mem_wb_flush = 1'b1;
          next_state   = MEM_WAIT;
        end else if (mem_NPCOp != NPC_SEQ) begin
          npc_sel      = mem_NPCOp;
          if_id_flush  = 1'b1;
          id_ex_flush  = 1'b1;
          ex_mem_flush = 1'b1;
        end else if (load_use) begin
          pc_stall    = 1'b1;
          if_id_stall = 1'b1;
          id_ex_flush = 1'b1;
        end
      end
      MEM_WAIT: begin
        dmem_req = 1'b1;
        if (dmem_ready) begin
          next_state = RUN;
        end else if (wait_cnt == WC_W'(MEM_TIMEOUT)) begin
          timeout    = 1'b1;
          next_state = RUN;
        end else begin
          {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall} = 4'b1111;
          mem_wb_flush = 1'b1;
        end
      end
      default: next_state = RUN;
    endcase
  end

`ifdef PIPE_PERF_CNT_EN
  logic redirect;
  assign redirect = (state == RUN) && !mem_miss && (mem_NPCOp != NPC_SEQ);

  pipe_perf_cnt #(.CNT_W(CNT_W)) u_perf_cnt (
    .clk          (clk),
    .rst          (rst),
    .stall_evt    (pc_stall),
    .flush_evt    (redirect),
    .stall_cycles (stall_cycles),
    .flush_events (flush_events)
  );
`else
  assign stall_cycles = '0;
  assign flush_events = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (MEM_TIMEOUT overridden to 4).
module tb_pipe_hazard_ctrl;

  localparam int CNT_W = 32;
  // Strobe vector: {pc, if_id, id_ex, ex_mem stall, if_id, id_ex, ex_mem, mem_wb flush}
  localparam logic [7:0] S_NONE = 8'b0000_0000;
  localparam logic [7:0] S_FULL = 8'b1111_0001;
  localparam logic [7:0] S_LU   = 8'b1100_0100;
  localparam logic [7:0] S_RD   = 8'b0000_1110;

  logic             clk = 1'b0;
  logic             rst;
  logic [4:0]       id_rs, id_rt, ex_wa;
  logic             id_uses_rt, ex_MemRead;
  logic [1:0]       mem_NPCOp;
  logic             mem_MemRead, mem_MemWrite, dmem_ready;
  logic             dmem_req;
  logic             pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
  logic             if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
  logic [1:0]       npc_sel;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cycles, flush_events;

  int checks   = 0;
  int failures = 0;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_MemRead(ex_MemRead), .ex_wa(ex_wa), .mem_NPCOp(mem_NPCOp),
    .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite), .dmem_ready(dmem_ready),
    .dmem_req(dmem_req), .pc_stall(pc_stall), .if_id_stall(if_id_stall),
    .id_ex_stall(id_ex_stall), .ex_mem_stall(ex_mem_stall), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush),
    .npc_sel(npc_sel), .mem_err(mem_err), .stall_cycles(stall_cycles),
    .flush_events(flush_events)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] strobes();
    return {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
            if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush};
  endfunction

  task automatic idle_inputs();
    id_rs = 0; id_rt = 0; ex_wa = 0; id_uses_rt = 0; ex_MemRead = 0;
    mem_NPCOp = 2'b00; mem_MemRead = 0; mem_MemWrite = 0; dmem_ready = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    #2;
    checks++;
    if (strobes() !== S_NONE || npc_sel !== 2'b00 || dmem_req !== 1'b0 || mem_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: strobes=%b npc=%b req=%b err=%b, required 0/00/0/0",
               strobes(), npc_sel, dmem_req, mem_err);
    end
    checks++;
    if (stall_cycles !== '0 || flush_events !== '0) begin
      failures++;
      $display("FAIL reset_counters: stall=%0d flush=%0d, required 0/0", stall_cycles, flush_events);
    end
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_load_use();
    idle_inputs();
    ex_MemRead = 1; ex_wa = 5; id_rs = 5;
    #1;
    checks++;
    if (strobes() !== S_LU || npc_sel !== 2'b00) begin
      failures++;
      $display("FAIL load_use_rs: strobes=%b npc=%b, required %b/00", strobes(), npc_sel, S_LU);
    end
    next_cycle();
    // Consumer has moved on: the bubble lasts one cycle only.
    idle_inputs();
    ex_wa = 5; id_rs = 5;
    #1;
    checks++;
    if (strobes() !== S_NONE) begin
      failures++;
      $display("FAIL load_use_one_bubble: strobes=%b, required %b", strobes(), S_NONE);
    end
    next_cycle();
    idle_inputs();
    ex_MemRead = 1; ex_wa = 0; id_rs = 0;
    #1;
    checks++;
    if (strobes() !== S_NONE) begin
      failures++;
      $display("FAIL load_use_r0: strobes=%b, required %b", strobes(), S_NONE);
    end
    next_cycle();
    idle_inputs();
    ex_MemRead = 1; ex_wa = 7; id_rs = 3; id_rt = 7; id_uses_rt = 1;
    #1;
    checks++;
    if (strobes() !== S_LU) begin
      failures++;
      $display("FAIL load_use_rt: strobes=%b, required %b", strobes(), S_LU);
    end
    next_cycle();
    id_uses_rt = 0;
    #1;
    checks++;
    if (strobes() !== S_NONE) begin
      failures++;
      $display("FAIL load_use_rt_unused: strobes=%b, required %b", strobes(), S_NONE);
    end
    next_cycle();
  endtask

  task automatic test_redirect();
    logic [1:0] ops [3];
    ops[0] = 2'b01; ops[1] = 2'b10; ops[2] = 2'b11;
    for (int i = 0; i < 3; i++) begin
      idle_inputs();
      ex_MemRead = 1; ex_wa = 9; id_rs = 9;
      mem_NPCOp = ops[i];
      #1;
      checks++;
      if (strobes() !== S_RD || npc_sel !== ops[i]) begin
        failures++;
        $display("FAIL redirect_%0d: strobes=%b npc=%b, required %b/%b",
                 i, strobes(), npc_sel, S_RD, ops[i]);
      end
      next_cycle();
    end
    idle_inputs();
    #1;
    checks++;
    if (strobes() !== S_NONE || npc_sel !== 2'b00) begin
      failures++;
      $display("FAIL redirect_idle: strobes=%b npc=%b, required 0/00", strobes(), npc_sel);
    end
    next_cycle();
  endtask

  task automatic test_mem_wait();
    idle_inputs();
    mem_MemRead = 1; dmem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (strobes() !== S_FULL || dmem_req !== 1'b1 || npc_sel !== 2'b00) begin
        failures++;
        $display("FAIL mem_wait_stall_%0d: strobes=%b req=%b npc=%b, required %b/1/00",
                 i, strobes(), dmem_req, npc_sel, S_FULL);
      end
      next_cycle();
    end
    dmem_ready = 1;
    #1;
    checks++;
    if (strobes() !== S_NONE || dmem_req !== 1'b1) begin
      failures++;
      $display("FAIL mem_wait_done: strobes=%b req=%b, required %b/1", strobes(), dmem_req, S_NONE);
    end
    next_cycle();
    idle_inputs();
    #1;
    checks++;
    if (dmem_req !== 1'b0 || strobes() !== S_NONE || mem_err !== 1'b0) begin
      failures++;
      $display("FAIL mem_wait_back_run: req=%b strobes=%b err=%b, required 0/0/0",
               dmem_req, strobes(), mem_err);
    end
    next_cycle();
    mem_MemWrite = 1; dmem_ready = 1;
    #1;
    checks++;
    if (strobes() !== S_NONE || dmem_req !== 1'b1) begin
      failures++;
      $display("FAIL zero_wait: strobes=%b req=%b, required %b/1", strobes(), dmem_req, S_NONE);
    end
    next_cycle();
    idle_inputs();
    #1;
    checks++;
    if (dmem_req !== 1'b0) begin
      failures++;
      $display("FAIL zero_wait_run: req=%b, required 0", dmem_req);
    end
    next_cycle();
  endtask

  task automatic test_timeout();
    idle_inputs();
    mem_MemWrite = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (strobes() !== S_FULL || mem_err !== 1'b0) begin
        failures++;
        $display("FAIL timeout_stall_%0d: strobes=%b err=%b, required %b/0", i, strobes(), mem_err, S_FULL);
      end
      next_cycle();
    end
    #1;
    checks++;
    if (strobes() !== S_NONE || dmem_req !== 1'b1) begin
      failures++;
      $display("FAIL timeout_release: strobes=%b req=%b, required %b/1", strobes(), dmem_req, S_NONE);
    end
    next_cycle();
    // Access still pending: a fresh miss starts while the error stays sticky.
    #1;
    checks++;
    if (mem_err !== 1'b1 || strobes() !== S_FULL) begin
      failures++;
      $display("FAIL timeout_err_set: err=%b strobes=%b, required 1/%b", mem_err, strobes(), S_FULL);
    end
    next_cycle();
    dmem_ready = 1;
    next_cycle();
    idle_inputs();
    next_cycle();
    #1;
    checks++;
    if (mem_err !== 1'b1 || dmem_req !== 1'b0) begin
      failures++;
      $display("FAIL timeout_err_sticky: err=%b req=%b, required 1/0", mem_err, dmem_req);
    end
    next_cycle();
  endtask

  task automatic test_reset_mid_wait();
    idle_inputs();
    mem_MemRead = 1;
    next_cycle();
    idle_inputs();
    #1;
    checks++;
    if (dmem_req !== 1'b1 || strobes() !== S_FULL) begin
      failures++;
      $display("FAIL mid_wait_entered: req=%b strobes=%b, required 1/%b", dmem_req, strobes(), S_FULL);
    end
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (dmem_req !== 1'b0 || strobes() !== S_NONE || mem_err !== 1'b0 || npc_sel !== 2'b00) begin
      failures++;
      $display("FAIL mid_wait_reset: req=%b strobes=%b err=%b npc=%b, required 0/0/0/00",
               dmem_req, strobes(), mem_err, npc_sel);
    end
    next_cycle();
    rst = 1'b0;
    next_cycle();
  endtask

  task automatic test_perf_counters();
    logic [CNT_W-1:0] exp_stall, exp_flush;
`ifdef PIPE_PERF_CNT_EN
    exp_stall = 3; exp_flush = 2;
`else
    exp_stall = 0; exp_flush = 0;
`endif
    rst = 1'b1;
    idle_inputs();
    next_cycle();
    rst = 1'b0;
    mem_NPCOp = 2'b01;
    next_cycle();
    mem_NPCOp = 2'b10;
    next_cycle();
    mem_NPCOp = 2'b00; mem_MemRead = 1; dmem_ready = 0;
    for (int i = 0; i < 3; i++) next_cycle();
    dmem_ready = 1;
    next_cycle();
    idle_inputs();
    next_cycle();
    checks++;
    if (stall_cycles !== exp_stall || flush_events !== exp_flush) begin
      failures++;
      $display("FAIL perf_counters: stall=%0d flush=%0d, required %0d/%0d",
               stall_cycles, flush_events, exp_stall, exp_flush);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_redirect();
    test_mem_wait();
    test_timeout();
    test_reset_mid_wait();
    test_perf_counters();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
